// File: rtl/fb_write_sched.sv
// Write-port scheduler for the frame buffer: arbitrates game pixel writes against a full-frame clear engine.
// Optional FB_VBLANK_SYNC_EN holds each clear until the next falling edge of vsync_n.
module fb_write_sched #(
   parameter int AW       = 16,
   parameter int DW       = 6,
   parameter int SCREEN_X = 184,
   parameter int SCREEN_Y = 184
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync_n,
   input  logic          clr_start,
   input  logic [DW-1:0] clr_color,
   output logic          clr_busy,
   output logic          clr_done,
   input  logic          req_valid,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
   output logic          req_ready,
   output logic          req_oob,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          mem_we
);

   localparam int unsigned   N         = SCREEN_X * SCREEN_Y;
   localparam logic [AW:0]   N_EXT     = (AW+1)'(N);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CLEAR   = 2'd1;
`ifdef FB_VBLANK_SYNC_EN
   localparam logic [1:0] ST_WAIT_VB = 2'd2;
`endif

   logic [1:0]    state;
   logic [AW-1:0] cnt;
   logic [DW-1:0] clr_col;
   logic          addr_in_range;
   logic          vsync_fall;

   // Widened compare so a frame filling the whole address space still works
   assign addr_in_range = ({1'b0, req_addr} < N_EXT);

`ifdef FB_VBLANK_SYNC_EN
   logic vsync_q;

   always_ff @(posedge clk) begin
      if (rst) vsync_q <= 1'b0;
      else     vsync_q <= vsync_n;
   end

   assign vsync_fall = vsync_q & ~vsync_n;
`else
   logic unused_vsync;
   assign unused_vsync = vsync_n;
   assign vsync_fall   = 1'b0;
`endif

   // clr_start wins over a same-cycle request, so requests are refused rather than dropped
   assign req_ready = ~rst & ~clr_start & (state == ST_IDLE);
   assign clr_busy  = (state != ST_IDLE);

   // During CLEAR, mem_addr always equals cnt: the start edge already registers address 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         clr_col  <= '0;
         mem_addr <= '0;
         mem_data <= '0;
         mem_we   <= 1'b0;
         clr_done <= 1'b0;
         req_oob  <= 1'b0;
      end else begin
         mem_we   <= 1'b0;
         clr_done <= 1'b0;
         req_oob  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clr_start) begin
                  clr_col <= clr_color;
                  cnt     <= '0;
`ifdef FB_VBLANK_SYNC_EN
                  state   <= ST_WAIT_VB;
`else
                  state    <= ST_CLEAR;
                  mem_we   <= 1'b1;
                  mem_addr <= '0;
                  mem_data <= clr_color;
`endif
               end else if (req_valid) begin
                  if (addr_in_range) begin
                     mem_we   <= 1'b1;
                     mem_addr <= req_addr;
                     mem_data <= req_data;
                  end else begin
                     req_oob <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               if (cnt == LAST_ADDR) begin
                  state    <= ST_IDLE;
                  clr_done <= 1'b1;
               end else begin
                  cnt      <= cnt + 1'b1;
                  mem_we   <= 1'b1;
                  mem_addr <= cnt + 1'b1;
                  mem_data <= clr_col;
               end
            end
`ifdef FB_VBLANK_SYNC_EN
            // An edge in the clr_start cycle is ignored because we are not yet in this state
            ST_WAIT_VB: begin
               if (vsync_fall) begin
                  state    <= ST_CLEAR;
                  mem_we   <= 1'b1;
                  mem_addr <= '0;
                  mem_data <= clr_col;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched on a 4x3 frame (N=12), default build without blanking sync.
module tb_fb_write_sched;

   localparam int AW = 16;
   localparam int DW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          vsync_n;
   logic          clr_start;
   logic [DW-1:0] clr_color;
   logic          clr_busy;
   logic          clr_done;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          req_ready;
   logic          req_oob;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_we;

   int numCompared   = 0;
   int numMismatched = 0;

   fb_write_sched #(.AW(AW), .DW(DW), .SCREEN_X(4), .SCREEN_Y(3)) dut (
      .clk(clk), .rst(rst), .vsync_n(vsync_n),
      .clr_start(clr_start), .clr_color(clr_color),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .req_oob(req_oob),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance to just after the next rising edge; registered outputs are stable here
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   int writes;
   int doneCycle;
   int badColor;

   initial begin
      rst = 1'b1; vsync_n = 1'b1; clr_start = 1'b0; clr_color = '0;
      req_valid = 1'b1; req_addr = 16'd4; req_data = 6'h05;
      applyStimulus();
      applyStimulus();
      checkOutput("rst_mem_we", 16'(mem_we), 16'd0);
      checkOutput("rst_mem_addr", mem_addr, 16'd0);
      checkOutput("rst_mem_data", 16'(mem_data), 16'd0);
      checkOutput("rst_busy", 16'(clr_busy), 16'd0);
      checkOutput("rst_done", 16'(clr_done), 16'd0);
      checkOutput("rst_oob", 16'(req_oob), 16'd0);
      checkOutput("rst_ready", 16'(req_ready), 16'd0);
      rst = 1'b0; req_valid = 1'b0;
      #1 checkOutput("ready_after_rst", 16'(req_ready), 16'd1);
      applyStimulus();

      // Single game write
      req_valid = 1'b1; req_addr = 16'd5; req_data = 6'h2A;
      #1 checkOutput("gw_ready", 16'(req_ready), 16'd1);
      applyStimulus();
      checkOutput("gw_we", 16'(mem_we), 16'd1);
      checkOutput("gw_addr", mem_addr, 16'd5);
      checkOutput("gw_data", 16'(mem_data), 16'h2A);

      // Back-to-back writes to 0,1,2 with data 1,2,3
      for (int i = 0; i < 3; i++) begin
         req_addr = 16'(i); req_data = 6'(i + 1);
         applyStimulus();
         checkOutput("b2b_we", 16'(mem_we), 16'd1);
         checkOutput("b2b_addr", mem_addr, 16'(i));
         checkOutput("b2b_data", 16'(mem_data), 16'(i + 1));
      end
      req_valid = 1'b0;
      applyStimulus();
      checkOutput("idle_we", 16'(mem_we), 16'd0);
      checkOutput("idle_addr_hold", mem_addr, 16'd2);

      // Out-of-range request at exactly N
      req_valid = 1'b1; req_addr = 16'd12; req_data = 6'h3F;
      #1 checkOutput("oob_ready", 16'(req_ready), 16'd1);
      applyStimulus();
      req_valid = 1'b0;
      checkOutput("oob_we", 16'(mem_we), 16'd0);
      checkOutput("oob_pulse", 16'(req_oob), 16'd1);
      checkOutput("oob_addr_hold", mem_addr, 16'd2);
      applyStimulus();
      checkOutput("oob_pulse_end", 16'(req_oob), 16'd0);

      // Reset in the middle of traffic
      req_valid = 1'b1; req_addr = 16'd7; req_data = 6'h11;
      applyStimulus();
      checkOutput("pre_rst_we", 16'(mem_we), 16'd1);
      rst = 1'b1;
      #1 checkOutput("mid_rst_ready", 16'(req_ready), 16'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("mid_rst_we", 16'(mem_we), 16'd0);
         checkOutput("mid_rst_addr", mem_addr, 16'd0);
         checkOutput("mid_rst_data", 16'(mem_data), 16'd0);
      end
      rst = 1'b0; req_valid = 1'b0;
      #1 checkOutput("mid_rst_ready_back", 16'(req_ready), 16'd1);
      applyStimulus();

      // Clear with a request held high throughout
      clr_start = 1'b1; clr_color = 6'b110000;
      req_valid = 1'b1; req_addr = 16'd9; req_data = 6'h15;
      #1 checkOutput("clr_same_cycle_ready", 16'(req_ready), 16'd0);
      applyStimulus();
      clr_start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         checkOutput("clr_we", 16'(mem_we), 16'd1);
         checkOutput("clr_addr", mem_addr, 16'(k));
         checkOutput("clr_data", 16'(mem_data), 16'b110000);
         checkOutput("clr_busy", 16'(clr_busy), 16'd1);
         checkOutput("clr_stall", 16'(req_ready), 16'd0);
         applyStimulus();
      end
      checkOutput("clr_done", 16'(clr_done), 16'd1);
      checkOutput("clr_busy_end", 16'(clr_busy), 16'd0);
      checkOutput("clr_end_we", 16'(mem_we), 16'd0);
      checkOutput("clr_end_ready", 16'(req_ready), 16'd1);
      applyStimulus();
      req_valid = 1'b0;
      checkOutput("pend_we", 16'(mem_we), 16'd1);
      checkOutput("pend_addr", mem_addr, 16'd9);
      checkOutput("pend_data", 16'(mem_data), 16'h15);
      checkOutput("pend_done_end", 16'(clr_done), 16'd0);
      applyStimulus();

      // Restart pulse during a clear is ignored
      clr_start = 1'b1; clr_color = 6'h0C;
      req_valid = 1'b1; req_addr = 16'd3; req_data = 6'h01;
      #1 checkOutput("restart_same_ready", 16'(req_ready), 16'd0);
      writes = 0; doneCycle = 0; badColor = 0;
      for (int c = 1; c <= 20; c++) begin
         applyStimulus();
         req_valid = 1'b0;
         if (mem_we) begin
            writes++;
            if (mem_data != 6'h0C) badColor++;
         end
         if (clr_done) doneCycle = c;
         clr_start = (c == 5);
         clr_color = (c == 5) ? 6'h3F : 6'h0C;
      end
      checkOutput("restart_writes", 16'(writes), 16'd12);
      checkOutput("restart_color", 16'(badColor), 16'd0);
      checkOutput("restart_done_cycle", 16'(doneCycle), 16'd13);
      checkOutput("restart_last_addr", mem_addr, 16'd11);

      // Reset during a clear aborts it without clr_done
      clr_start = 1'b1; clr_color = 6'h21;
      writes = 0; doneCycle = 0;
      for (int c = 1; c <= 20; c++) begin
         applyStimulus();
         clr_start = 1'b0;
         if (mem_we) writes++;
         if (clr_done) doneCycle = c;
         rst = (c == 6);
      end
      checkOutput("abort_writes", 16'(writes), 16'd6);
      checkOutput("abort_no_done", 16'(doneCycle), 16'd0);
      checkOutput("abort_busy", 16'(clr_busy), 16'd0);
      checkOutput("abort_ready", 16'(req_ready), 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
